axis_frame_streamer: RTL and testbench

- On-chip AXI-Stream transmitter on the design_clk domain that plays back DMA-width frames from a local buffer.
- Produces the same beat format the input stream interface consumes: 64-bit tdata, 8-bit tkeep, tlast on the final beat.
- Replaces the external DMA source for self-test and coefficient reload, and feeds the receive path of the design.

---
 rtl/axis_frame_streamer.sv | 157 +++++++++++++++
 tb/tb_axis_frame_streamer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_streamer.sv
// rtl/axis_frame_streamer.sv - plays back buffered DMA-width frames as an AXI-Stream source
// Buffer read has one-cycle latency; a 2-entry skid on the output keeps one beat per cycle.
module axis_frame_streamer #(
   parameter int DMA_WIDTH = 64,
   parameter int DEPTH     = 256,
   parameter int AW        = 8
) (
   input  logic                   design_clk,
   input  logic                   design_rst,
   input  logic                   wr_en,
   input  logic [AW-1:0]          wr_addr,
   input  logic [DMA_WIDTH-1:0]   wr_data,
   input  logic                   start,
   input  logic [AW:0]            frame_len,
   input  logic [DMA_WIDTH/8-1:0] last_keep,
   output logic [DMA_WIDTH-1:0]   m_axis_tdata,
   output logic [DMA_WIDTH/8-1:0] m_axis_tkeep,
   output logic                   m_axis_tlast,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready,
   output logic                   busy,
   output logic                   done,
   output logic                   err
);
   localparam int KW = DMA_WIDTH / 8;
   localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE_L   = (AW+1)'(1);

   typedef enum logic {S_IDLE, S_STREAM} state_t;
   typedef struct packed {
      logic [DMA_WIDTH-1:0] data;
      logic [KW-1:0]        keep;
      logic                 last;
   } beat_t;
   localparam beat_t BEAT_RST = beat_t'({{DMA_WIDTH{1'b0}}, {KW{1'b1}}, 1'b0});

   state_t               state_q, state_d;
   logic [DMA_WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]          len_q, len_d, rd_idx_q, rd_idx_d;
   logic [KW-1:0]        lkeep_q, lkeep_d;
   beat_t                rd_q, rd_d, s0_q, s0_d, s1_q, s1_d;
   logic                 rd_valid_q, rd_valid_d;
   logic [1:0]           cnt_q, cnt_d, cnt_tmp;
   logic                 done_q, done_d, err_q, err_d;
   logic                 busy_w, wr_ok, start_ok, start_zero, pop, issue, is_last;
   logic [AW:0]          len_clamp, cur_len;
   logic [KW-1:0]        cur_keep;
   logic [AW-1:0]        rd_addr;
   logic [2:0]           occ;

   always_comb begin
      busy_w     = (state_q == S_STREAM);
      wr_ok      = wr_en & ~busy_w;
      start_ok   = start & ~busy_w & (frame_len != '0);
      start_zero = start & ~busy_w & (frame_len == '0);
      len_clamp  = (frame_len > DEPTH_L) ? DEPTH_L : frame_len;
      pop        = (cnt_q != 2'd0) & m_axis_tready;
      // Beats held in the skid plus the read in flight, after this cycle's pop.
      occ        = {1'b0, cnt_q} + {2'b00, rd_valid_q} - {2'b00, pop};

      state_d  = state_q;
      len_d    = len_q;
      lkeep_d  = lkeep_q;
      rd_idx_d = rd_idx_q;
      rd_addr  = rd_idx_q[AW-1:0];
      cur_len  = len_q;
      cur_keep = lkeep_q;
      issue    = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start_ok) begin
               state_d  = S_STREAM;
               len_d    = len_clamp;
               lkeep_d  = last_keep;
               cur_len  = len_clamp;
               cur_keep = last_keep;
               rd_addr  = '0;
               issue    = 1'b1;
            end
         end
         S_STREAM: begin
            if ((rd_idx_q < len_q) && (occ < 3'd2)) issue = 1'b1;
            if (pop && s0_q.last) state_d = S_IDLE;
         end
      endcase

      is_last = (rd_idx_q == cur_len - ONE_L);
      if (issue) rd_idx_d = rd_idx_q + ONE_L;
      if (busy_w && (state_d == S_IDLE)) rd_idx_d = '0;

      rd_valid_d = issue;
      rd_d       = rd_q;
      if (issue) begin
         rd_d.data = (wr_ok && (wr_addr == rd_addr)) ? wr_data : mem_q[rd_addr];
         rd_d.keep = is_last ? cur_keep : {KW{1'b1}};
         rd_d.last = is_last;
      end

      s0_d    = s0_q;
      s1_d    = s1_q;
      cnt_tmp = cnt_q;
      if (pop) begin
         s0_d    = s1_q;
         cnt_tmp = cnt_q - 2'd1;
      end
      if (rd_valid_q) begin
         if (cnt_tmp == 2'd0) s0_d = rd_q;
         else                 s1_d = rd_q;
         cnt_tmp = cnt_tmp + 2'd1;
      end
      cnt_d = cnt_tmp;

      done_d = (busy_w & pop & s0_q.last) | start_zero;
      err_d  = (busy_w & (start | wr_en)) | start_zero;
   end

   always_ff @(posedge design_clk) begin
      if (wr_ok) mem_q[wr_addr] <= wr_data;
   end

   always_ff @(posedge design_clk) begin
      if (design_rst) begin
         state_q    <= S_IDLE;
         len_q      <= '0;
         lkeep_q    <= '0;
         rd_idx_q   <= '0;
         rd_q       <= BEAT_RST;
         rd_valid_q <= 1'b0;
         s0_q       <= BEAT_RST;
         s1_q       <= BEAT_RST;
         cnt_q      <= 2'd0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         lkeep_q    <= lkeep_d;
         rd_idx_q   <= rd_idx_d;
         rd_q       <= rd_d;
         rd_valid_q <= rd_valid_d;
         s0_q       <= s0_d;
         s1_q       <= s1_d;
         cnt_q      <= cnt_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign m_axis_tdata  = s0_q.data;
   assign m_axis_tkeep  = s0_q.keep;
   assign m_axis_tlast  = s0_q.last;
   assign m_axis_tvalid = (cnt_q != 2'd0);
   assign busy          = (state_q == S_STREAM);
   assign done          = done_q;
   assign err           = err_q;
endmodule

// File: tb/tb_axis_frame_streamer.sv
// tb/tb_axis_frame_streamer.sv - directed and randomized checks of axis_frame_streamer
module tb_axis_frame_streamer;
   localparam int DEPTH = 256;

   logic        clk = 1'b0;
   logic        design_rst, wr_en, start, tready;
   logic [7:0]  wr_addr;
   logic [63:0] wr_data;
   logic [8:0]  frame_len;
   logic [7:0]  last_keep;
   logic [63:0] tdata;
   logic [7:0]  tkeep;
   logic        tlast, tvalid, busy, done, err;

   always #5 clk = ~clk;

   axis_frame_streamer #(.DMA_WIDTH(64), .DEPTH(DEPTH), .AW(8)) dut (
      .design_clk(clk), .design_rst(design_rst),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .start(start), .frame_len(frame_len), .last_keep(last_keep),
      .m_axis_tdata(tdata), .m_axis_tkeep(tkeep), .m_axis_tlast(tlast),
      .m_axis_tvalid(tvalid), .m_axis_tready(tready),
      .busy(busy), .done(done), .err(err)
   );

   typedef struct packed {
      logic [63:0] d;
      logic [7:0]  k;
      logic        l;
   } beat_s;

   int          n_chk = 0, n_fail = 0, cyc = 0;
   beat_s       obs_q[$];
   logic [63:0] model_mem [DEPTH];
   int          done_cnt = 0, err_cnt = 0, first_tv = -1, first_hs = -1, last_hs = -1;
   int          done_cyc = -1, err_cyc = -1, start_cyc = 0;
   bit          prev_stall = 1'b0;
   beat_s       prev_beat;
   bit          pat [7] = '{1, 0, 0, 1, 0, 1, 1};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
      n_chk++;
      assert (o === e) else begin
         n_fail++;
         $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, o, e);
      end
   endtask

   always @(negedge clk) begin
      if (!design_rst) begin
         if (prev_stall) begin
            chk("hold_data", tdata, prev_beat.d);
            chk("hold_keep_last_valid", {tkeep, tlast, tvalid}, {prev_beat.k, prev_beat.l, 1'b1});
         end
         if (tvalid && first_tv < 0) first_tv = cyc;
         if (tvalid && tready) begin
            obs_q.push_back('{tdata, tkeep, tlast});
            if (first_hs < 0) first_hs = cyc;
            last_hs = cyc;
         end
         if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = cyc; end
         if (err)  begin err_cnt++;  if (err_cyc < 0)  err_cyc = cyc;  end
         prev_stall = tvalid && !tready;
         prev_beat  = '{tdata, tkeep, tlast};
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int a, input logic [63:0] d);
      wr_en = 1'b1; wr_addr = a[7:0]; wr_data = d;
      tick();
      wr_en = 1'b0;
      model_mem[a] = d;
   endtask

   task automatic clear_mon();
      obs_q.delete();
      done_cnt = 0; err_cnt = 0; first_tv = -1; first_hs = -1; last_hs = -1;
      done_cyc = -1; err_cyc = -1;
   endtask

   task automatic check_frame(input string nm, input int eff, input logic [7:0] lk);
      chk({nm, "_count"}, obs_q.size(), eff);
      for (int i = 0; i < eff && i < obs_q.size(); i++) begin
         chk($sformatf("%s_data%0d", nm, i), obs_q[i].d, model_mem[i]);
         chk($sformatf("%s_keep%0d", nm, i), obs_q[i].k, (i == eff - 1) ? lk : 8'hFF);
         chk($sformatf("%s_last%0d", nm, i), obs_q[i].l, (i == eff - 1));
      end
   endtask

   // mode: 0 tready always 1, 1 fixed toggle pattern, 2 random; inj: 1 start+write while busy, 2 write-first at start
   task automatic run_frame(input string nm, input int len, input logic [7:0] lk, input int mode, input int inj);
      int eff;
      bit fin;
      eff = (len > DEPTH) ? DEPTH : len;
      fin = 1'b0;
      clear_mon();
      start = 1'b1; frame_len = len[8:0]; last_keep = lk; tready = 1'b1;
      start_cyc = cyc;
      if (inj == 2) begin
         wr_en = 1'b1; wr_addr = 8'd0; wr_data = {$urandom, $urandom};
         model_mem[0] = wr_data;
      end
      tick();
      start = 1'b0; wr_en = 1'b0;
      for (int k = 1; k < 4 * eff + 40; k++) begin
         case (mode)
            0:       tready = 1'b1;
            1:       tready = pat[(k + 5) % 7];
            default: tready = ($urandom_range(0, 3) != 0);
         endcase
         if (inj == 1 && k == 3) begin start = 1'b1; frame_len = 9'd5; end
         if (inj == 1 && k == 5) begin wr_en = 1'b1; wr_addr = 8'd5; wr_data = ~model_mem[5]; end
         tick();
         start = 1'b0; wr_en = 1'b0;
         if (done_cnt > 0) begin fin = 1'b1; break; end
      end
      tready = 1'b1;
      tick(); tick();
      chk({nm, "_finished"}, fin, 1);
      check_frame(nm, eff, lk);
      chk({nm, "_done_cnt"}, done_cnt, 1);
      chk({nm, "_err_cnt"}, err_cnt, (inj == 1) ? 2 : ((eff == 0) ? 1 : 0));
      chk({nm, "_busy_after"}, busy, 0);
      chk({nm, "_tvalid_after"}, tvalid, 0);
      if (eff > 0) begin
         chk({nm, "_latency"}, first_tv - start_cyc, 2);
         chk({nm, "_done_cycle"}, done_cyc - last_hs, 1);
         if (mode == 0) chk({nm, "_no_bubbles"}, last_hs - first_hs, eff - 1);
      end else begin
         chk({nm, "_no_tvalid"}, first_tv, -1);
         chk({nm, "_done_next"}, done_cyc - start_cyc, 1);
         chk({nm, "_err_next"}, err_cyc - start_cyc, 1);
      end
   endtask

   initial begin
      logic [7:0] lk;
      design_rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      start = 1'b0; frame_len = '0; last_keep = '0; tready = 1'b1;
      repeat (3) tick();
      chk("rst_tvalid", tvalid, 0);
      chk("rst_tlast", tlast, 0);
      chk("rst_busy_done_err", {busy, done, err}, 3'b000);
      chk("rst_tdata", tdata, 64'h0);
      chk("rst_tkeep", tkeep, 8'hFF);
      design_rst = 1'b0;
      tick();

      for (int k = 0; k < 4; k++) wr(k, 64'h1111_0000_0000_0000 | 64'(k));
      run_frame("basic", 4, 8'h0F, 0, 0);
      run_frame("stall", 4, 8'h0F, 1, 0);
      run_frame("one", 1, 8'h01, 0, 0);
      run_frame("zero", 0, 8'h01, 0, 0);

      for (int k = 0; k < 8; k++) wr(k, {$urandom, $urandom});
      lk = 8'($urandom_range(1, 255));
      run_frame("busy_inj", 8, lk, 2, 1);
      run_frame("reread", 8, lk, 2, 0);
      run_frame("wrfirst", 3, 8'h3F, 0, 2);

      for (int k = 0; k < DEPTH; k++) wr(k, 64'(k));
      run_frame("full", 256, 8'h7F, 0, 0);
      run_frame("clamp", 511, 8'hF0, 2, 0);

      for (int k = 0; k < 6; k++) wr(k, {$urandom, $urandom});
      clear_mon();
      start = 1'b1; frame_len = 9'd6; last_keep = 8'h03; tready = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      chk("rst_mid_beat3_valid", tvalid, 1);
      design_rst = 1'b1;
      tick();
      chk("rst_mid_tvalid", tvalid, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_tlast", tlast, 0);
      chk("rst_mid_tdata", tdata, 64'h0);
      chk("rst_mid_tkeep", tkeep, 8'hFF);
      design_rst = 1'b0;
      repeat (5) tick();
      chk("rst_mid_no_done", done_cnt, 0);
      chk("rst_mid_beats_before", obs_q.size(), 3);
      run_frame("post_rst", 6, 8'h03, 1, 0);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end
endmodule
